ex_stage_muldiv: RTL and testbench
==================================

# ex_stage_muldiv

Execute stage of the RV32 pipeline, placed between the ID/EX register and the EX/MEM register. It computes single-cycle integer ALU results combinationally and runs iterative unsigned multiply/divide over 32 cycles. While a multi-cycle operation is in progress it stalls the front end, and it presents bubbles to EX/MEM because that register has no enable.

## Interface
- N, 32, datapath width. The iteration count equals N.
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low. Clears all state.
- flush  in  1  active-low, synchronous. Aborts the current instruction.
- in_valid  in  1  ID/EX holds a valid instruction.
- op_a  in  N  source operand A (rs1 or forwarded value).
- op_b  in  N  source operand B (rs2 or immediate).
- alu_op  in  4  operation code:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU
  - 10 MUL, 11 MULHU, 12 DIVU, 13 REMU
  - 14 and 15 are reserved and return 0.
- rd  in  5  destination register.
- reg_write  in  1  instruction writes rd.
- alu_result_w  out  N  result to EX/MEM.
- write_w  out  1  write enable to EX/MEM.
- write_register_w  out  5  destination register to EX/MEM.
- stall_o  out  1  holds the PC, IF/ID and ID/EX.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, single-cycle op (0–9, 14, 15), in_valid=1:
  - Outputs are combinational in the same cycle: result, write_w=reg_write, write_register_w=rd.
  - stall_o=0.
- IDLE, in_valid=0:
  - alu_result_w=0, write_w=0, write_register_w=0, stall_o=0.
- IDLE, multi-cycle op (10–13), in_valid=1:
  - stall_o=1 combinationally; write_w=0.
  - At the clock edge, latch operands, alu_op, rd and reg_write; clear the counter; go to BUSY.
- BUSY:
  - One iteration per cycle; stall_o=1; write_w=0; alu_result_w=0.
  - After N iterations go to DONE.
- DONE:
  - Drive the latched result, write_w=latched reg_write, write_register_w=latched rd.
  - stall_o=0. Next state is IDLE unconditionally.
  - The ID/EX instruction is not re-accepted in DONE; it advances at this edge.
- Multiply:
  - Shift-add over a 2N-bit product.
  - MUL returns product[N-1:0]; MULHU returns product[2N-1:N].
- Divide:
  - Restoring, unsigned.
  - DIVU returns the quotient; REMU returns the remainder.
  - Divide by zero is not special-cased; the algorithm must yield quotient all-ones and remainder op_a, matching the RISC-V spec.
- Shifts use op_b[4:0]. SLT is a signed compare; SLTU is unsigned. Results are 1 or 0, zero-extended.
- ADD and SUB wrap modulo 2^N.
- Flush (flush=0):
  - Outputs are forced combinationally: write_w=0, stall_o=0, alu_result_w=0, write_register_w=0.
  - At the edge, state goes to IDLE and the counter is cleared.
  - Flush overrides a new accept in the same cycle.
- Reset (reset=0):
  - State goes to IDLE; counter, latches and product/remainder registers go to 0.
  - While asserted, outputs are alu_result_w=0, write_w=0, write_register_w=0, stall_o=0.
  - Reset mid-BUSY discards the operation; no write is emitted.

## Timing
- Single-cycle ops: 0 cycles of added latency. EX/MEM captures the result at the next edge.
- Multi-cycle op accepted in cycle 0:
  - stall_o=1 in cycles 0 through N (N+1 cycles).
  - Result is valid in cycle N+1 (DONE), with stall_o=0.
  - Total occupancy is N+2 cycles: 34 at N=32.
- write_w pulses exactly one cycle per accepted instruction. No duplicate writes, including for back-to-back multi-cycle ops.
- Back-to-back: a multi-cycle op present in IDLE immediately after DONE is accepted in that IDLE cycle. There is no dead cycle beyond DONE.
- Flush and reset take precedence over every state transition. Priority is reset > flush > FSM.

## Test plan
- ADD: op_a=5, op_b=7, rd=3, reg_write=1 → same cycle alu_result_w=12, write_w=1, write_register_w=3, stall_o=0.
- Signed/unsigned compare and shift: SLT with op_a=0xFFFFFFFF, op_b=1 → 1. SLTU with the same operands → 0. SRA of 0x80000000 by 4 → 0xF8000000.
- Multiply:
  - MULHU 0x00010000 × 0x00010000 → stall_o=1 for cycles 0–32, write_w=0 for cycles 0–32; cycle 33 gives result 1, write_w=1.
  - MUL with the same operands → 0.
  - MUL 0xFFFFFFFF × 0xFFFFFFFF → 1.
- Divide:
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - DIVU 55/0 → 0xFFFFFFFF; REMU 55/0 → 55.
  - Each divide takes 34 cycles, with exactly one write_w pulse.
- Flush and reset:
  - flush=0 in BUSY cycle 10 → state IDLE next cycle, stall_o=0, no write_w pulse for that op.
  - reset=0 asserted mid-BUSY → all outputs 0 immediately (asynchronous).
- Back-to-back: DIVU (rd=4), then MUL (rd=5), then ADD (rd=6) → write_w pulses at cycles 33, 67 and 68 with the correct rd. Exactly three pulses in total.

Source files
------------

// File: rtl/ex_stage_muldiv.sv
// RV32 execute stage: combinational ALU plus an iterative unsigned multiply/divide
// unit that stalls the front end and emits one write to EX/MEM per instruction.
module ex_stage_muldiv #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    input  logic [3:0]   alu_op,
    input  logic [4:0]   rd,
    input  logic         reg_write,
    output logic [N-1:0] alu_result_w,
    output logic         write_w,
    output logic [4:0]   write_register_w,
    output logic         stall_o
);
    localparam int CW = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_hi;
    logic [N-1:0]  r_lo;
    logic [3:0]    r_op;
    logic [4:0]    r_rd;
    logic          r_wr;

    logic          w_is_md;
    logic          w_is_div;
    logic [N-1:0]  w_alu;
    logic [N-1:0]  w_md_result;
    logic [N:0]    w_mul_sum;
    logic [N:0]    w_div_shift;
    logic          w_div_ge;
    logic [N-1:0]  w_div_sub;
    logic [N-1:0]  w_hi_next;
    logic [N-1:0]  w_lo_next;

    assign w_is_md  = (alu_op >= OP_MUL) && (alu_op <= OP_REMU);
    assign w_is_div = (r_op == OP_DIVU) || (r_op == OP_REMU);

    // {r_hi, r_lo} is the product shifting right for multiply, and
    // {remainder, quotient} shifting left for divide.
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_div_shift = {r_hi, r_lo[N-1]};
    assign w_div_ge    = w_div_shift >= {1'b0, r_b};
    assign w_div_sub   = w_div_shift[N-1:0] - r_b;

    always_comb begin
        w_hi_next = w_mul_sum[N:1];
        w_lo_next = {w_mul_sum[0], r_lo[N-1:1]};
        if (w_is_div) begin
            w_hi_next = w_div_ge ? w_div_sub : w_div_shift[N-1:0];
            w_lo_next = {r_lo[N-2:0], w_div_ge};
        end
    end

    always_comb begin
        w_alu = '0;
        case (alu_op)
            OP_ADD:  w_alu = op_a + op_b;
            OP_SUB:  w_alu = op_a - op_b;
            OP_AND:  w_alu = op_a & op_b;
            OP_OR:   w_alu = op_a | op_b;
            OP_XOR:  w_alu = op_a ^ op_b;
            OP_SLL:  w_alu = op_a << op_b[4:0];
            OP_SRL:  w_alu = op_a >> op_b[4:0];
            OP_SRA:  w_alu = $signed(op_a) >>> op_b[4:0];
            OP_SLT:  w_alu = {{(N-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: w_alu = {{(N-1){1'b0}}, op_a < op_b};
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_md_result = r_lo;
        if ((r_op == OP_MULHU) || (r_op == OP_REMU)) begin
            w_md_result = r_hi;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_op    <= '0;
            r_rd    <= '0;
            r_wr    <= 1'b0;
        end else if (!flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && w_is_md) begin
                        r_hi    <= '0;
                        r_lo    <= op_a;
                        r_b     <= op_b;
                        r_op    <= alu_op;
                        r_rd    <= rd;
                        r_wr    <= reg_write;
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_hi  <= w_hi_next;
                    r_lo  <= w_lo_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(N - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                // The held ID/EX instruction is the one just completed; it advances now.
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        alu_result_w     = '0;
        write_w          = 1'b0;
        write_register_w = '0;
        stall_o          = 1'b0;
        if (reset && flush) begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_is_md) begin
                            stall_o = 1'b1;
                        end else begin
                            alu_result_w     = w_alu;
                            write_w          = reg_write;
                            write_register_w = rd;
                        end
                    end
                end
                S_BUSY: stall_o = 1'b1;
                S_DONE: begin
                    alu_result_w     = w_md_result;
                    write_w          = r_wr;
                    write_register_w = r_rd;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Self-checking bench for ex_stage_muldiv: directed cases plus random ops against
// an arithmetic reference model, with a write-pulse monitor for timing checks.
module tb_ex_stage_muldiv;
    localparam int N = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] alu_result_w;
    logic        write_w;
    logic [4:0]  write_register_w;
    logic        stall_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulse_cyc[$];
    int pulse_rd[$];

    ex_stage_muldiv #(.N(N)) dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .in_valid         (in_valid),
        .op_a             (op_a),
        .op_b             (op_b),
        .alu_op           (alu_op),
        .rd               (rd),
        .reg_write        (reg_write),
        .alu_result_w     (alu_result_w),
        .write_w          (write_w),
        .write_register_w (write_register_w),
        .stall_o          (stall_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (write_w) begin
            pulse_cyc.push_back(cyc);
            pulse_rd.push_back(int'(write_register_w));
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint unsigned p;
        int unsigned sh;
        p  = longint'(a) * longint'(b);
        sh = int'(b[4:0]);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return 32'($signed(a) >>> sh);
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return p[31:0];
            4'd11:   return p[63:32];
            4'd12:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd13:   return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Call just after a rising edge; returns just after the edge ending the instruction.
    task automatic exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic w);
        logic [31:0] exp;
        int sc;
        int wc;
        in_valid  = 1'b1;
        alu_op    = op;
        op_a      = a;
        op_b      = b;
        rd        = d;
        reg_write = w;
        exp       = ref_model(op, a, b);
        if (op >= 4'd10 && op <= 4'd13) begin
            sc = 0;
            wc = 0;
            for (int c = 0; c <= N; c++) begin
                @(negedge clk);
                if (stall_o) sc++;
                if (write_w) wc++;
                @(posedge clk);
                #1;
            end
            check_eq("md_stall_cycles", 64'(sc), 64'(N + 1));
            check_eq("md_early_write", 64'(wc), 64'd0);
        end
        @(negedge clk);
        check_eq("result", 64'(alu_result_w), 64'(exp));
        check_eq("write_w", 64'(write_w), 64'(w));
        check_eq("write_reg", 64'(write_register_w), 64'(d));
        check_eq("stall_after", 64'(stall_o), 64'd0);
        $display("op=%0d a=%h b=%h rd=%0d we=%0d res=%h exp=%h", op, a, b, d, w,
                 alu_result_w, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int c0;
        logic [3:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        reset = 1'b0; flush = 1'b1; in_valid = 1'b1;
        alu_op = 4'd0; op_a = 32'd5; op_b = 32'd7; rd = 5'd3; reg_write = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_result", 64'(alu_result_w), 64'd0);
        check_eq("rst_write", 64'(write_w), 64'd0);
        check_eq("rst_wreg", 64'(write_register_w), 64'd0);
        check_eq("rst_stall", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        exec(4'd0, 32'd5, 32'd7, 5'd3, 1'b1);
        exec(4'd8, 32'hFFFF_FFFF, 32'd1, 5'd1, 1'b1);
        exec(4'd9, 32'hFFFF_FFFF, 32'd1, 5'd1, 1'b1);
        exec(4'd7, 32'h8000_0000, 32'd4, 5'd2, 1'b1);
        exec(4'd15, 32'h1234, 32'h5678, 5'd7, 1'b1);

        idle(1);
        @(negedge clk);
        check_eq("idle_result", 64'(alu_result_w), 64'd0);
        check_eq("idle_write", 64'(write_w), 64'd0);
        check_eq("idle_stall", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1;

        exec(4'd11, 32'h0001_0000, 32'h0001_0000, 5'd8, 1'b1);
        exec(4'd10, 32'h0001_0000, 32'h0001_0000, 5'd9, 1'b1);
        exec(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b1);
        exec(4'd12, 32'd100, 32'd7, 5'd11, 1'b1);
        exec(4'd13, 32'd100, 32'd7, 5'd12, 1'b1);
        exec(4'd12, 32'd55, 32'd0, 5'd13, 1'b1);
        exec(4'd13, 32'd55, 32'd0, 5'd14, 1'b1);

        // Back-to-back DIVU, MUL, ADD: pulses expected at +33, +67, +68.
        pulse_cyc.delete();
        pulse_rd.delete();
        c0 = cyc;
        exec(4'd12, 32'd1000, 32'd9, 5'd4, 1'b1);
        exec(4'd10, 32'd12345, 32'd678, 5'd5, 1'b1);
        exec(4'd0, 32'd1, 32'd2, 5'd6, 1'b1);
        idle(3);
        check_eq("b2b_pulses", 64'(pulse_cyc.size()), 64'd3);
        if (pulse_cyc.size() == 3) begin
            check_eq("b2b_cyc0", 64'(pulse_cyc[0] - c0), 64'd33);
            check_eq("b2b_cyc1", 64'(pulse_cyc[1] - c0), 64'd67);
            check_eq("b2b_cyc2", 64'(pulse_cyc[2] - c0), 64'd68);
            check_eq("b2b_rd0", 64'(pulse_rd[0]), 64'd4);
            check_eq("b2b_rd1", 64'(pulse_rd[1]), 64'd5);
            check_eq("b2b_rd2", 64'(pulse_rd[2]), 64'd6);
        end

        // Flush in BUSY cycle 10.
        pulse_cyc.delete();
        in_valid = 1'b1; alu_op = 4'd12; op_a = 32'd500; op_b = 32'd3; rd = 5'd20; reg_write = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("pre_flush_stall", 64'(stall_o), 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_eq("flush_stall", 64'(stall_o), 64'd0);
        check_eq("flush_write", 64'(write_w), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("post_flush_stall", 64'(stall_o), 64'd0);
        idle(40);
        check_eq("flush_no_write", 64'(pulse_cyc.size()), 64'd0);

        // Flush overrides acceptance in IDLE.
        in_valid = 1'b1; alu_op = 4'd10; op_a = 32'd3; op_b = 32'd4; rd = 5'd21;
        flush = 1'b0;
        @(negedge clk);
        check_eq("flush_acc_stall", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("flush_acc_idle", 64'(stall_o), 64'd0);
        idle(40);
        check_eq("flush_acc_no_write", 64'(pulse_cyc.size()), 64'd0);

        // Asynchronous reset mid-BUSY.
        in_valid = 1'b1; alu_op = 4'd13; op_a = 32'd77; op_b = 32'd5; rd = 5'd22;
        repeat (6) @(posedge clk);
        #2;
        check_eq("pre_rst_stall", 64'(stall_o), 64'd1);
        reset = 1'b0;
        #1;
        check_eq("arst_stall", 64'(stall_o), 64'd0);
        check_eq("arst_write", 64'(write_w), 64'd0);
        check_eq("arst_result", 64'(alu_result_w), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(40);
        check_eq("arst_no_write", 64'(pulse_cyc.size()), 64'd0);
        exec(4'd13, 32'd77, 32'd5, 5'd22, 1'b1);

        for (int t = 0; t < 40; t++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = $urandom;
            r_b  = $urandom;
            if ($urandom_range(0, 3) == 0) r_b = r_b & 32'h1F;
            if ((r_op == 4'd12 || r_op == 4'd13) && $urandom_range(0, 3) == 0) r_b = 32'd0;
            exec(r_op, r_a, r_b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
